// File: rtl/cpu_pkg.sv
// Shared constants for the CPU slice: byte/word widths and the program loader FSM encoding.
// Optional loader checksum state CHK is only reachable when LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 16;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] HDR_HI  = 3'd0;
  localparam logic [STATE_W-1:0] HDR_LO  = 3'd1;
  localparam logic [STATE_W-1:0] DATA_HI = 3'd2;
  localparam logic [STATE_W-1:0] DATA_LO = 3'd3;
  localparam logic [STATE_W-1:0] DRAIN   = 3'd4;
  localparam logic [STATE_W-1:0] DONE    = 3'd5;
  localparam logic [STATE_W-1:0] ERR     = 3'd6;
  localparam logic [STATE_W-1:0] CHK     = 3'd7;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: length header + N big-endian words into imem, then releases the CPU.
// Latency: imem_we pulses the cycle after each word's low byte; backpressure via rx_ready (low outside byte-accepting states).
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [15:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [STATE_W-1:0] AFTER_LAST = CHK;
  logic [BYTE_W-1:0] csum;
`else
  localparam logic [STATE_W-1:0] AFTER_LAST = DRAIN;
`endif

  logic [STATE_W-1:0] state;
  logic [BYTE_W-1:0]  len_hi;
  logic [BYTE_W-1:0]  data_hi;
  logic [16:0]        n_words;
  logic [16:0]        word_cnt;
  logic [15:0]        n_hdr;
  logic               accept;

  assign n_hdr  = {len_hi, rx_data};
  assign accept = rx_valid && rx_ready;

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:                              rx_ready = 1'b1;
`endif
      default:                          rx_ready = 1'b0;
    endcase
  end

  assign cpu_reset  = (state != DONE);
  assign load_done  = (state == DONE);
  assign load_error = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR_HI;
      len_hi     <= '0;
      data_hi    <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR_HI: if (accept) begin
          len_hi <= rx_data;
          state  <= HDR_LO;
        end
        HDR_LO: if (accept) begin
          n_words  <= {1'b0, n_hdr};
          word_cnt <= '0;
          if ({1'b0, n_hdr} > DEPTH)
            state <= ERR;
          else if (n_hdr == 16'd0)
            state <= AFTER_LAST;
          else
            state <= DATA_HI;
        end
        DATA_HI: if (accept) begin
          data_hi <= rx_data;
          state   <= DATA_LO;
        end
        DATA_LO: if (accept) begin
          imem_we    <= 1'b1;
          imem_addr  <= 16'(word_cnt[ADDR_W-1:0]);
          imem_wdata <= {data_hi, rx_data};
          word_cnt   <= word_cnt + 17'd1;
          state      <= (word_cnt + 17'd1 == n_words) ? AFTER_LAST : DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (accept) begin
          state <= (rx_data == csum) ? DRAIN : ERR;
        end
`endif
        // One settle cycle so cpu_reset drops strictly after the last imem write.
        DRAIN: state <= DONE;
        DONE: if (reload) begin
          state    <= HDR_HI;
          word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum     <= '0;
`endif
        end
        ERR:     state <= ERR;
        default: state <= HDR_HI;
      endcase
`ifdef LOADER_CHECKSUM_EN
      if (accept && (state == HDR_HI || state == HDR_LO ||
                     state == DATA_HI || state == DATA_LO))
        csum <= csum ^ rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected imem writes are queued as frames are sent and
// popped by a write monitor; build with or without LOADER_CHECKSUM_EN.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int checks   = 0;
  int errors   = 0;
  int n_writes = 0;
  logic [31:0] exp_q[$];

  program_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued (addr,data).
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write got=%h_%h expected=none", imem_addr, imem_wdata);
      end
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({imem_addr, imem_wdata} === e) else begin
          errors++;
          $error("FAIL imem_write got=%h_%h expected=%h_%h", imem_addr, imem_wdata, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the edge where rx_ready is high.
  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout got=rx_ready_low expected=accept byte %h", b);
    end
    step();
    rx_valid = 1'b0;
    if (gap) step();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int wbase;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0;
    repeat (3) step();
    chk("rst_rx_ready",   32'(rx_ready),   32'd1);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_imem_addr",  32'(imem_addr),  32'd0);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_cpu_reset",  32'(cpu_reset),  32'd1);
    chk("rst_load_done",  32'(load_done),  32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    step();

    // Two-word frame, valid every cycle.
    exp_q.push_back({16'd0, 16'h1234});
    exp_q.push_back({16'd1, 16'hABCD});
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("f1_chk_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h42, 0);
`else
    chk("f1_last_we", 32'(imem_we), 32'd1);
`endif
    chk("f1_drain_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("f1_drain_done",      32'(load_done), 32'd0);
    step();
    chk("f1_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("f1_load_done", 32'(load_done), 32'd1);
    chk("f1_rx_ready",  32'(rx_ready),  32'd0);
    chk("f1_q_empty",   32'(exp_q.size()), 32'd0);
    do_reload();
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_load_done", 32'(load_done), 32'd0);
    chk("reload_rx_ready",  32'(rx_ready),  32'd1);

    // Same frame with rx_valid toggling.
    wbase = n_writes;
    exp_q.push_back({16'd0, 16'h1234});
    exp_q.push_back({16'd1, 16'hABCD});
    send(8'h00, 1); send(8'h02, 1); send(8'h12, 1); send(8'h34, 1); send(8'hAB, 1); send(8'hCD, 1);
`ifdef LOADER_CHECKSUM_EN
    send(8'h42, 1);
`endif
    repeat (2) step();
    chk("f2_load_done", 32'(load_done), 32'd1);
    chk("f2_writes",    32'(n_writes - wbase), 32'd2);
    chk("f2_q_empty",   32'(exp_q.size()), 32'd0);
    do_reload();

    // Empty image.
    wbase = n_writes;
    send(8'h00, 0); send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    step();
    chk("f3_load_done", 32'(load_done), 32'd1);
    chk("f3_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("f3_writes",    32'(n_writes - wbase), 32'd0);
    do_reload();

    // Reset mid-frame, then a fresh one-word frame.
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    pulse_reset();
    chk("mid_rst_rx_ready",  32'(rx_ready),  32'd1);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_imem_we",   32'(imem_we),   32'd0);
    exp_q.push_back({16'd0, 16'h55AA});
    send(8'h00, 0); send(8'h01, 0); send(8'h55, 0); send(8'hAA, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'hFE, 0);
`endif
    step();
    chk("f4_load_done", 32'(load_done), 32'd1);
    chk("f4_q_empty",   32'(exp_q.size()), 32'd0);
    do_reload();

`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back({16'd0, 16'h1234});
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h27, 0);
    step();
    chk("ck_good_done", 32'(load_done), 32'd1);
    do_reload();
    exp_q.push_back({16'd0, 16'h1234});
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'hFF, 0);
    chk("ck_bad_error", 32'(load_error), 32'd1);
    chk("ck_bad_done",  32'(load_done),  32'd0);
    pulse_reset();
`endif

    // Largest legal length: 256 words proceeds to the data phase.
    send(8'h01, 0); send(8'h00, 0);
    chk("n256_rx_ready",   32'(rx_ready),   32'd1);
    chk("n256_load_error", 32'(load_error), 32'd0);
    pulse_reset();

    // Oversize length: sticky error, reload ignored.
    wbase = n_writes;
    send(8'h01, 0); send(8'h01, 0);
    chk("ovf_load_error", 32'(load_error), 32'd1);
    chk("ovf_cpu_reset",  32'(cpu_reset),  32'd1);
    chk("ovf_rx_ready",   32'(rx_ready),   32'd0);
    reload = 1'b1;
    repeat (3) step();
    reload = 1'b0;
    step();
    chk("ovf_reload_error", 32'(load_error), 32'd1);
    chk("ovf_reload_done",  32'(load_done),  32'd0);
    chk("ovf_writes",       32'(n_writes - wbase), 32'd0);
    pulse_reset();
    chk("ovf_rst_error", 32'(load_error), 32'd0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of instruction memory depth in words.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  incoming load-stream byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at a rising edge.
REQ-007 SHALL have port reload  input  1  restart request, honoured only in DONE.
REQ-008 SHALL have port imem_we  output  1  instruction memory write strobe, one-cycle pulse per word.
REQ-009 SHALL have port imem_addr  output  16  word address; upper 16-ADDR_W bits always zero.
REQ-010 SHALL have port imem_wdata  output  16  instruction word, {high byte, low byte}.
REQ-011 SHALL have port cpu_reset  output  1  holds CPU (PC, register file) in reset while high.
REQ-012 SHALL have port load_done  output  1  image loaded and CPU released.
REQ-013 SHALL have port load_error  output  1  image rejected; CPU held.

Function
REQ-014 SHALL accept frames: length high byte, length low byte (word count N), then N words each high byte then low byte.
REQ-015 SHALL implement FSM states HDR_HI, HDR_LO, DATA_HI, DATA_LO, DRAIN, DONE, ERR (plus CHK under REQ-027).
REQ-016 SHALL assert rx_ready only in HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK; each accepted byte advances exactly one state.
REQ-017 SHALL, on HDR_LO acceptance, go to ERR if N > 2**ADDR_W, to DRAIN if N == 0, else to DATA_HI.
REQ-018 SHALL, on DATA_LO acceptance, drive imem_we=1 for exactly the next cycle with imem_addr = word index (0..N-1) and imem_wdata = {hi, lo}.
REQ-019 SHALL, after the write of word N-1, enter DRAIN; DRAIN lasts one cycle, then DONE.
REQ-020 SHALL keep cpu_reset=1 in every state except DONE; cpu_reset falls no earlier than one cycle after the final imem_we pulse.
REQ-021 SHALL drive load_done=1 only in DONE and load_error=1 only in ERR.
REQ-022 SHALL, in DONE with reload=1, return to HDR_HI, clear word index, assert cpu_reset the next cycle.
REQ-023 SHALL hold ERR until reset; reload ignored in ERR and in all non-DONE states.
REQ-024 SHALL treat rx_valid=0 as a stall with no state change; no byte is dropped or duplicated.

Reset
REQ-025 SHALL, on reset, enter HDR_HI with rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, word index and checksum cleared.
REQ-026 SHALL let reset asserted mid-frame discard the partial frame; already-written words are not erased.

Configuration
REQ-027 SHALL, with LOADER_CHECKSUM_EN defined, expect one trailing byte equal to XOR of all length and payload bytes, entering CHK instead of DRAIN after the last write (or after HDR_LO when N == 0); match -> DRAIN, mismatch -> ERR.
REQ-028 SHALL, without LOADER_CHECKSUM_EN, omit CHK state and checksum register entirely.

Structure
REQ-029 SHALL place the FSM state encoding and byte/word width constants in shared package cpu_pkg.
REQ-030 SHALL be a single module with no sub-modules; byte assembly, counter and checksum inline.

Verification
REQ-031 Bytes 00 02 12 34 AB CD, valid every cycle -> imem writes (0,1234),(1,ABCD); cpu_reset falls one cycle after DRAIN; load_done=1.
REQ-032 Header 00 00 -> no imem_we; DONE reached; CHK byte 00 required when LOADER_CHECKSUM_EN.
REQ-033 ADDR_W=8, header 01 01 -> ERR, load_error=1, cpu_reset=1, rx_ready=0, reload ignored.
REQ-034 Same frame as REQ-031 with rx_valid toggled 1/0 -> identical writes, one per word.
REQ-035 Reset after byte 12 of REQ-031 frame -> back to HDR_HI; new frame 00 01 55 AA writes (0,55AA).
REQ-036 LOADER_CHECKSUM_EN: 00 01 12 34 then 27 -> DONE; then FF -> ERR.
